// File: rtl/interrupt_controller.sv
// Edge-detecting, masked, fixed-priority interrupt feeder with hold-off spacing between pulses.
// Optional macro IRQ_SYNC_EN inserts a two-flop synchronizer on irq_in ahead of edge detection.
module interrupt_controller #(
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned HOLDOFF = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic               clear_wr,
    input  logic [IDW-1:0]     clear_idx,
    output logic               interrupt,
    output logic [IDW-1:0]     irq_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask,
    output logic               busy
);
    localparam int unsigned CW = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [NUM_IRQ-1:0] irq_src;
    logic [NUM_IRQ-1:0] irq_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] serviced;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [IDW-1:0]     winner;
    logic               fire;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign irq_src = sync2;
`else
    assign irq_src = irq_in;
`endif

    // Edge history: a held level triggers only once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_d <= '0;
        end else begin
            irq_d <= irq_src;
        end
    end

    assign rise     = irq_src & ~irq_d;
    assign eligible = pending & mask;
    assign busy     = (state == S_HOLD);

    // Lowest eligible index wins
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IDW'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (eligible != '0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = CW'(HOLDOFF - 1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) state_nxt = S_IDLE;
                else           cnt_nxt   = cnt - CW'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pulse decision and pending update; a new rise beats any clear on the same edge
    always_comb begin
        fire        = (state == S_IDLE) && (eligible != '0);
        serviced    = '0;
        pending_nxt = pending;
        if (fire) serviced = eligible & (~eligible + NUM_IRQ'(1));
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (rise[i])                                   pending_nxt[i] = 1'b1;
            else if (clear_wr && (clear_idx == IDW'(i)))   pending_nxt[i] = 1'b0;
            else if (serviced[i])                          pending_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            interrupt <= 1'b0;
            irq_id    <= '0;
            pending   <= '0;
            mask      <= '0;
        end else begin
            interrupt <= fire;
            if (fire)    irq_id <= winner;
            pending <= pending_nxt;
            if (mask_wr) mask   <= mask_data;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized plus directed bench for interrupt_controller against a cycle-count reference model.
module tb_interrupt_controller;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 2;
    localparam int unsigned H   = 8;
`ifdef IRQ_SYNC_EN
    localparam int          LAT = 4;
`else
    localparam int          LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] irq_in = '0;
    logic         mask_wr = 1'b0;
    logic [N-1:0] mask_data = '0;
    logic         clear_wr = 1'b0;
    logic [W-1:0] clear_idx = '0;
    logic         interrupt;
    logic [W-1:0] irq_id;
    logic [N-1:0] pending;
    logic [N-1:0] mask;
    logic         busy;

    int n_tot = 0;
    int n_bad = 0;

    interrupt_controller #(.NUM_IRQ(N), .IDW(W), .HOLDOFF(H)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .mask_wr(mask_wr),
        .mask_data(mask_data), .clear_wr(clear_wr), .clear_idx(clear_idx),
        .interrupt(interrupt), .irq_id(irq_id), .pending(pending),
        .mask(mask), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: pulses gated by an absolute "next allowed edge" number
    int unsigned m_pend, m_mask, m_prev, m_id, m_int, m_s1, m_s2;
    longint      edge_k, next_ok;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_prev = 0; m_id = 0; m_int = 0;
        m_s1 = 0; m_s2 = 0; edge_k = 0; next_ok = 0;
    endtask

    task automatic model_edge();
        int unsigned src, rise, elig, npend;
`ifdef IRQ_SYNC_EN
        src  = m_s2;
        m_s2 = m_s1;
        m_s1 = int'(irq_in);
`else
        src  = int'(irq_in);
`endif
        rise   = src & ~m_prev;
        m_prev = src;
        elig   = m_pend & m_mask;
        npend  = m_pend;
        m_int  = 0;
        if (edge_k >= next_ok && elig != 0) begin
            for (int b = N - 1; b >= 0; b--)
                if (((elig >> b) & 1) != 0) m_id = b;
            m_int   = 1;
            npend   = npend & ~(32'd1 << m_id);
            next_ok = edge_k + H + 1;
        end
        if (clear_wr && int'(clear_idx) < N) npend = npend & ~(32'd1 << clear_idx);
        npend = npend | rise;
        if (mask_wr) m_mask = int'(mask_data);
        m_pend = npend & ((32'd1 << N) - 1);
        edge_k++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".interrupt"}, 32'(interrupt), m_int);
        chk({tag, ".irq_id"},    32'(irq_id),    m_id);
        chk({tag, ".pending"},   32'(pending),   m_pend);
        chk({tag, ".mask"},      32'(mask),      m_mask);
        chk({tag, ".busy"},      32'(busy),      32'(edge_k < next_ok));
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge
    task automatic cycle(input logic [N-1:0] irq, input logic mw, input logic [N-1:0] md,
                         input logic cw, input logic [W-1:0] ci);
        irq_in = irq; mask_wr = mw; mask_data = md; clear_wr = cw; clear_idx = ci;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic flush();
        repeat (20) cycle('0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic wait_pulse(input logic [N-1:0] irq, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            cycle(irq, 1'b0, '0, 1'b0, '0);
            if (interrupt === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input logic [N-1:0] irq, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            cycle(irq, 1'b0, '0, 1'b0, '0);
            if (interrupt === 1'b1) n++;
        end
    endtask

    // Asynchronous reset asserted mid-cycle, held across an edge, released at negedge
    task automatic do_reset();
        #1 reset = 1'b0;
        model_reset();
        #1 check_all("rst_async");
        irq_in = '0; mask_wr = 1'b0; clear_wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all("rst_hold");
        reset = 1'b1;
    endtask

    initial begin
        int n;
        logic [N-1:0] r_irq;
        model_reset();
        @(negedge clk);
        check_all("reset");
        reset = 1'b1;

        // Single source, held level
        flush();
        cycle('0, 1'b1, 4'b1111, 1'b0, '0);
        wait_pulse(4'b0100, n);
        chk("t2_lat", 32'(n), 32'(LAT));
        chk("t2_id", 32'(irq_id), 32'd2);
        chk("t2_pend", 32'(pending), 32'd0);
        count_pulses(4'b0100, 20, n);
        chk("t2_held", 32'(n), 32'd0);

        // Priority and hold-off spacing
        flush();
        wait_pulse(4'b1010, n);
        chk("t3_id1", 32'(irq_id), 32'd1);
        chk("t3_busy", 32'(busy), 32'd1);
        wait_pulse(4'b1010, n);
        chk("t3_gap", 32'(n), 32'(H + 1));
        chk("t3_id3", 32'(irq_id), 32'd3);

        // Masked source latches; unmask fires; clear before unmask suppresses
        flush();
        cycle('0, 1'b1, 4'b1110, 1'b0, '0);
        count_pulses(4'b0001, 10, n);
        chk("t4_masked", 32'(n), 32'd0);
        chk("t4_pend", 32'(pending), 32'd1);
        cycle(4'b0001, 1'b1, 4'b1111, 1'b0, '0);
        wait_pulse(4'b0001, n);
        chk("t4_unmask", 32'(n), 32'd1);
        chk("t4_id", 32'(irq_id), 32'd0);
        flush();
        cycle('0, 1'b1, 4'b1110, 1'b0, '0);
        repeat (4) cycle(4'b0001, 1'b0, '0, 1'b0, '0);
        cycle(4'b0001, 1'b0, '0, 1'b1, 2'd0);
        cycle(4'b0001, 1'b1, 4'b1111, 1'b0, '0);
        count_pulses(4'b0001, 15, n);
        chk("t4_cleared", 32'(n), 32'd0);

        // Rise colliding with a clear of the same bit
        flush();
        cycle(4'b1000, 1'b0, '0, 1'b1, 2'd3);
        wait_pulse(4'b1000, n);
        chk("t5_found", 32'(n > 0), 32'd1);
        chk("t5_id", 32'(irq_id), 32'd3);

        // Reset mid-hold with work pending
        flush();
        wait_pulse(4'b0111, n);
        chk("t1_id", 32'(irq_id), 32'd0);
        chk("t1_pend", 32'(pending), 32'b0110);
        cycle(4'b0111, 1'b0, '0, 1'b0, '0);
        do_reset();
        chk("t1_pend0", 32'(pending), 32'd0);
        count_pulses(4'b0001, LAT + 2, n);
        chk("t1_nopulse", 32'(n), 32'd0);
        chk("t1_pend1", 32'(pending), 32'd1);

        // Random traffic
        r_irq = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            r_irq = r_irq ^ N'($urandom & $urandom);
            cycle(r_irq, $urandom_range(0, 15) == 0, N'($urandom),
                  $urandom_range(0, 7) == 0, W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule
